fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the processor's decode/execute datapath. It owns the PC and issues word fetches to the instruction memory over a request/grant interface with in-order, variable-latency responses. Fetched words are buffered with their PCs in a small queue and handed to decode over a valid/ready handshake. Jump/branch redirects flush the queue and discard in-flight responses.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues in-order word
// fetches to instruction memory, buffers returned words with their PCs and
// hands them to decode. Redirects flush the buffer and drop stale responses.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          queue_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [31:0]     fetch_pc;
  logic [31:0]     resp_pc;
  logic [31:0]     redirect_word;

  logic            grant;
  logic            push;
  logic            pop;
  logic            unused_pc_bits;

  // Word-aligned redirect target; the low two bits are ignored by design.
  assign redirect_word  = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Issue throttle uses only registered occupancy, so out_ready never reaches imem_req.
  always_comb begin
    imem_req  = ((SW'(count) + SW'(outstanding)) < SW'(DEPTH)) & ~redirect;
    imem_addr = fetch_pc;
    grant     = imem_req & imem_gnt;
    push      = imem_rvalid & (discard == '0) & ~redirect;
    pop       = out_valid & out_ready;
  end

  // Head of queue presented to decode; zeroed when empty.
  always_comb begin
    out_valid = (count != '0);
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = queue_mem[head].pc;
      out_instr = queue_mem[head].instr;
    end
  end

  // Control state: PCs, occupancy, in-flight and discard accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      // Everything still owed after this cycle belongs to the old stream.
      fetch_pc    <= redirect_word;
      resp_pc     <= redirect_word;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(imem_rvalid);
      discard     <= outstanding - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (imem_rvalid) begin
        if (discard != '0) begin
          discard <= discard - CW'(1);
        end else begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[tail] <= '{pc: resp_pc, instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with an in-order memory model and an
// epoch-tagged reference model of the delivered instruction stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    int          ep;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          epoch  = 0;
  int          gnt_pct, rv_pct, rdy_pct, lat_min, lat_max;
  mreq_t       mem_q[$];
  ent_t        q_out[$];
  logic [31:0] exp_fetch;
  logic        exp_req;
  logic [97:0] exp_vec;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [97:0] observe();
    return {imem_req, imem_req ? imem_addr : 32'h0, out_valid, out_pc, out_instr};
  endfunction

  // Memory and decode side stimulus for the current cycle.
  task automatic drive_mem();
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (mem_q.size() > 0 && mem_q[0].rdy <= cyc && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    out_ready   = ($urandom_range(99) < rdy_pct);
    redirect    = 1'b0;
    redirect_pc = $urandom;
  endtask

  // Expected visible outputs from the model for the driven inputs.
  task automatic calc_exp();
    ent_t h;
    exp_req = ((q_out.size() + mem_q.size()) < DEPTH) && !redirect;
    if (q_out.size() != 0) h = q_out[0];
    else begin
      h.pc  = 32'h0;
      h.ins = 32'h0;
    end
    exp_vec = {exp_req, exp_req ? exp_fetch : 32'h0, (q_out.size() != 0), h.pc, h.ins};
  endtask

  // Apply this cycle's events to the model, then move to the next cycle.
  task automatic advance();
    mreq_t m;
    ent_t  e;
    if (q_out.size() != 0 && out_ready) void'(q_out.pop_front());
    if (redirect) begin
      q_out.delete();
      epoch++;
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end
    if (imem_rvalid && mem_q.size() != 0) begin
      m = mem_q.pop_front();
      if (m.ep == epoch) begin
        e.pc  = m.addr;
        e.ins = mem_word(m.addr);
        q_out.push_back(e);
      end
    end
    if (exp_req && imem_gnt) begin
      m.addr = exp_fetch;
      m.rdy  = cyc + int'($urandom_range(lat_max, lat_min));
      m.ep   = epoch;
      mem_q.push_back(m);
      exp_fetch = exp_fetch + 32'd4;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    mem_q.delete();
    q_out.delete();
    exp_fetch = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_mode(input int g, input int rv, input int rd, input int lmin, input int lmax);
    gnt_pct = g; rv_pct = rv; rdy_pct = rd; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    do_reset();
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    checks++;
    if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++; $display("FAIL reset_out got pc=%h instr=%h exp 0/0", out_pc, out_instr);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] next_pc = 32'h0;
    int delivered = 0;
    bit seen = 0;
    int bubbles = 0;
    set_mode(100, 100, 100, 1, 1);
    for (int i = 0; i < 40; i++) begin
      drive_mem(); calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      if (seen && !out_valid) bubbles++;
      if (out_valid && out_ready) begin
        seen = 1;
        checks++;
        if (out_pc !== next_pc || out_instr !== mem_word(next_pc)) begin
          errors++; $display("FAIL stream_order got pc=%h instr=%h exp pc=%h", out_pc, out_instr, next_pc);
        end
        next_pc = next_pc + 32'd4;
        delivered++;
      end
      advance();
    end
    checks++;
    if (bubbles != 0 || delivered != 38) begin
      errors++; $display("FAIL stream_rate got delivered=%0d bubbles=%0d exp 38/0", delivered, bubbles);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] next_pc = 32'h0;
    bit first_req = 1;
    do_reset();
    set_mode(100, 100, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      drive_mem(); calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL bp_fill cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      advance();
    end
    drive_mem(); calc_exp(); #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL bp_full got req=%b valid=%b pc=%h exp 0/1/0", imem_req, out_valid, out_pc);
    end
    advance();
    set_mode(100, 100, 100, 1, 1);
    for (int i = 0; i < 12; i++) begin
      drive_mem(); calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      if (imem_req && first_req) begin
        first_req = 0;
        checks++;
        if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_resume got=%h exp=00000010", imem_addr); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== next_pc) begin errors++; $display("FAIL bp_order got=%h exp=%h", out_pc, next_pc); end
        next_pc = next_pc + 32'd4;
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    bit fired = 0;
    bit first = 1;
    bit seen = 0;
    do_reset();
    set_mode(100, 100, 100, 4, 4);
    for (int i = 0; i < 20 && !fired; i++) begin
      drive_mem();
      if (mem_q.size() == 2) begin
        redirect = 1'b1; redirect_pc = 32'h0000_1002; fired = 1;
      end
      calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL redir_pre cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      if (fired) begin
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_low got=%b exp=0", imem_req); end
      end
      advance();
    end
    checks++;
    if (!fired) begin errors++; $display("FAIL redir_setup got=timeout exp=2 outstanding"); end
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_mem(); calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL redir_post cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      if (first) begin
        first = 0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin
          errors++; $display("FAIL redir_addr got req=%b addr=%h exp 1/00001000", imem_req, imem_addr);
        end
      end
      if (out_valid) begin
        seen = 1;
        checks++;
        if (out_pc !== 32'h1000) begin errors++; $display("FAIL redir_first got=%h exp=00001000", out_pc); end
      end
      advance();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL redir_deliver got=timeout exp=out_valid"); end
  endtask

  task automatic test_redirect_collide();
    bit fired = 0;
    bit seen = 0;
    logic [31:0] hd = 32'h0;
    do_reset();
    set_mode(100, 100, 0, 2, 2);
    for (int i = 0; i < 30 && !fired; i++) begin
      drive_mem();
      if (imem_rvalid && q_out.size() >= 1 && mem_q.size() >= 2) begin
        redirect = 1'b1; redirect_pc = 32'h0000_2000; out_ready = 1'b1;
        hd = q_out[0].pc; fired = 1;
      end
      calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL coll_pre cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      advance();
    end
    checks++;
    if (!fired) begin errors++; $display("FAIL coll_setup got=timeout exp=collision"); end
    set_mode(100, 100, 100, 2, 2);
    for (int i = 0; i < 15; i++) begin
      drive_mem(); calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL coll_post cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      if (out_valid && !seen) begin
        seen = 1;
        checks++;
        if (out_pc !== 32'h2000 || out_instr !== mem_word(32'h2000)) begin
          errors++; $display("FAIL coll_first got pc=%h instr=%h exp pc=00002000 (old head %h)", out_pc, out_instr, hd);
        end
      end
      advance();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL coll_deliver got=timeout exp=out_valid"); end
  endtask

  task automatic test_async_reset();
    bit ok = 0;
    bit seen = 0;
    do_reset();
    set_mode(100, 100, 0, 1, 1);
    for (int i = 0; i < 20 && !ok; i++) begin
      drive_mem(); calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL arst_fill cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      if (q_out.size() == 3) ok = 1;
      else advance();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL arst_setup got=timeout exp=3 queued"); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
    #1 rst_n = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL arst_async got valid=%b pc=%h req=%b addr=%h exp 0/0/1/%h",
                         out_valid, out_pc, imem_req, imem_addr, RESET_PC);
    end
    mem_q.delete();
    q_out.delete();
    exp_fetch = RESET_PC;
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_mode(100, 100, 100, 1, 1);
    for (int i = 0; i < 10; i++) begin
      drive_mem(); calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL arst_post cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      if (out_valid && !seen) begin
        seen = 1;
        checks++;
        if (out_pc !== RESET_PC) begin errors++; $display("FAIL arst_restart got=%h exp=%h", out_pc, RESET_PC); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    set_mode(70, 75, 60, 1, 5);
    for (int i = 0; i < 1500; i++) begin
      drive_mem();
      if ($urandom_range(99) < 4) begin
        redirect = 1'b1;
        redirect_pc = $urandom;
      end
      calc_exp(); #1;
      checks++;
      if (observe() !== exp_vec) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec); end
      advance();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
